// File: rtl/tx_fifo_mgnt_if.sv
// rtl/tx_fifo_mgnt_if.sv - client write and engine read signals of the tx FIFO manager
interface tx_fifo_mgnt_if;
   // client write side
   logic [63:0] tx_data;
   logic [7:0]  tx_data_valid;
   logic        tx_eof;
   logic        tx_fifo_afull;
   logic        tx_frame_dropped;
   // engine read side
   logic        tx_rd_en;
   logic [63:0] txd64;
   logic [7:0]  txc_fifo;
   logic        txd_eof;
   logic        txd_valid;
   logic        frame_avail;
   logic        fifo_empty;

   modport master (
      output tx_data, tx_data_valid, tx_eof, tx_rd_en,
      input  tx_fifo_afull, tx_frame_dropped, txd64, txc_fifo, txd_eof,
             txd_valid, frame_avail, fifo_empty
   );

   modport slave (
      input  tx_data, tx_data_valid, tx_eof, tx_rd_en,
      output tx_fifo_afull, tx_frame_dropped, txd64, txc_fifo, txd_eof,
             txd_valid, frame_avail, fifo_empty
   );
endinterface

// File: rtl/tx_fifo_mgnt.sv
// rtl/tx_fifo_mgnt.sv - transmit frame FIFO with commit-on-eof and whole-frame drop on overflow
module tx_fifo_mgnt #(
   parameter int DEPTH_LOG2   = 5,
   parameter int AFULL_THRESH = 4
) (
   input  logic            txclk,
   input  logic            reset,
   tx_fifo_mgnt_if.slave   bus
);
   localparam int             DEPTH   = 1 << DEPTH_LOG2;
   localparam int             PW      = DEPTH_LOG2 + 1;
   localparam logic [PW-1:0]  DEPTH_P = PW'(DEPTH);
   localparam logic [PW-1:0]  AFULL_P = PW'(AFULL_THRESH);

   typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} wstate_t;

   // entry layout: {eof, lane mask, data}
   logic [72:0]     mem [DEPTH];

   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   commit_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   frame_cnt;
   logic [PW-1:0]   used;
   logic [PW-1:0]   free_words;
   wstate_t         wstate;
   wstate_t         wstate_nxt;
   logic            wr_strobe;
   logic            full;
   logic            do_write;
   logic            do_commit;
   logic            do_drop;
   logic            rd_ok;
   logic            rd_eof;
   logic [72:0]     rd_word;

   // occupancy counts uncommitted words too, so a frame cannot overrun unread data
   assign wr_strobe  = |bus.tx_data_valid;
   assign used       = wr_ptr - rd_ptr;
   assign full       = (used == DEPTH_P);
   assign free_words = DEPTH_P - used;
   assign rd_ok      = bus.tx_rd_en && (rd_ptr != commit_ptr);
   assign rd_word    = mem[rd_ptr[DEPTH_LOG2-1:0]];
   assign rd_eof     = rd_word[72];

   assign bus.tx_fifo_afull = (free_words <= AFULL_P);
   assign bus.fifo_empty    = (rd_ptr == commit_ptr);
   assign bus.frame_avail   = (frame_cnt != '0);

   // write FSM state register
   always_ff @(posedge txclk or negedge reset) begin
      if (!reset) wstate <= W_IDLE;
      else        wstate <= wstate_nxt;
   end

   // write FSM: decide write, commit or drop for the current client word
   always_comb begin
      wstate_nxt = wstate;
      do_write   = 1'b0;
      do_commit  = 1'b0;
      do_drop    = 1'b0;
      case (wstate)
         W_IDLE, W_FRAME: begin
            if (wr_strobe) begin
               if (full) begin
                  do_drop    = 1'b1;
                  wstate_nxt = bus.tx_eof ? W_IDLE : W_DROP;
               end else begin
                  do_write = 1'b1;
                  if (bus.tx_eof) begin
                     do_commit  = 1'b1;
                     wstate_nxt = W_IDLE;
                  end else begin
                     wstate_nxt = W_FRAME;
                  end
               end
            end
         end
         W_DROP: begin
            if (wr_strobe && bus.tx_eof) wstate_nxt = W_IDLE;
         end
         default: wstate_nxt = W_IDLE;
      endcase
   end

   // storage array; no reset needed since only committed entries are ever read
   always_ff @(posedge txclk) begin
      if (do_write) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {bus.tx_eof, bus.tx_data_valid, bus.tx_data};
   end

   // write and commit pointers; a drop rolls the write pointer back to the last commit
   always_ff @(posedge txclk or negedge reset) begin
      if (!reset) begin
         wr_ptr               <= '0;
         commit_ptr           <= '0;
         bus.tx_frame_dropped <= 1'b0;
      end else begin
         if (do_drop)       wr_ptr <= commit_ptr;
         else if (do_write) wr_ptr <= wr_ptr + 1'b1;
         if (do_commit)     commit_ptr <= wr_ptr + 1'b1;
         bus.tx_frame_dropped <= do_drop;
      end
   end

   // read port: registered outputs that hold their value when no read is accepted
   always_ff @(posedge txclk or negedge reset) begin
      if (!reset) begin
         rd_ptr        <= '0;
         bus.txd64     <= '0;
         bus.txc_fifo  <= '0;
         bus.txd_eof   <= 1'b0;
         bus.txd_valid <= 1'b0;
      end else begin
         bus.txd_valid <= rd_ok;
         if (rd_ok) begin
            rd_ptr       <= rd_ptr + 1'b1;
            bus.txd64    <= rd_word[63:0];
            bus.txc_fifo <= rd_word[71:64];
            bus.txd_eof  <= rd_word[72];
         end
      end
   end

   // count of complete frames still stored
   always_ff @(posedge txclk or negedge reset) begin
      if (!reset) begin
         frame_cnt <= '0;
      end else begin
         case ({do_commit, rd_ok && rd_eof})
            2'b10:   frame_cnt <= frame_cnt + 1'b1;
            2'b01:   frame_cnt <= frame_cnt - 1'b1;
            default: frame_cnt <= frame_cnt;
         endcase
      end
   end
endmodule

// File: tb/tb_tx_fifo_mgnt.sv
// tb/tb_tx_fifo_mgnt.sv - table and scoreboard bench for tx_fifo_mgnt
module tb_tx_fifo_mgnt;
   localparam int DEPTH = 32;
   localparam int AFULL = 4;

   typedef struct {
      logic [7:0]  mask;
      logic        eof;
      logic        rd;
      logic [63:0] data;
      logic        exp_valid;
      logic        exp_avail;
      logic        exp_empty;
   } vec_t;

   logic txclk = 1'b0;
   logic reset;
   always #5 txclk = ~txclk;

   tx_fifo_mgnt_if bus();

   tx_fifo_mgnt #(.DEPTH_LOG2(5), .AFULL_THRESH(AFULL)) dut (
      .txclk (txclk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   int          drop_seen = 0;
   logic [72:0] sb[$];
   logic [72:0] pend[$];
   bit          m_drop = 0;
   logic [72:0] last_word = '0;
   logic [7:0]  masks [8];
   vec_t        tv [8];

   task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic int eof_count();
      int c = 0;
      foreach (sb[i]) if (sb[i][72]) c++;
      return c;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // drive one cycle, update the model, check every output after the edge
   task automatic drive_cycle(input logic [7:0] mask, input logic eof, input logic rd,
                              input logic [63:0] data);
      bit full, exp_drop, exp_valid;
      bus.tx_data       = data;
      bus.tx_data_valid = mask;
      bus.tx_eof        = eof;
      bus.tx_rd_en      = rd;
      full      = (sb.size() + pend.size()) == DEPTH;
      exp_valid = rd && (sb.size() != 0);
      exp_drop  = 0;
      if (mask != 8'h00) begin
         if (m_drop) begin
            if (eof) m_drop = 0;
         end else if (full) begin
            pend.delete();
            exp_drop = 1;
            m_drop   = !eof;
         end else begin
            pend.push_back({eof, mask, data});
            if (eof) begin
               foreach (pend[i]) sb.push_back(pend[i]);
               pend.delete();
            end
         end
      end
      @(posedge txclk);
      @(negedge txclk);
      if (exp_valid) last_word = sb.pop_front();
      chk("txd_valid", bus.txd_valid, exp_valid);
      chk("txd_word", {bus.txd_eof, bus.txc_fifo, bus.txd64}, last_word);
      chk("frame_dropped", bus.tx_frame_dropped, exp_drop);
      chk("frame_avail", bus.frame_avail, eof_count() != 0);
      chk("fifo_empty", bus.fifo_empty, sb.size() == 0);
      chk("afull", bus.tx_fifo_afull, (DEPTH - sb.size() - pend.size()) <= AFULL);
      if (bus.tx_frame_dropped) drop_seen++;
   endtask

   task automatic write_frame(input int len, input logic rd);
      for (int i = 0; i < len; i++)
         drive_cycle((i == len - 1) ? masks[$urandom_range(7)] : 8'hFF, i == len - 1, rd, rnd64());
   endtask

   task automatic read_cycles(input int n);
      for (int i = 0; i < n; i++) drive_cycle(8'h00, 1'b0, 1'b1, rnd64());
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_txd_valid"}, bus.txd_valid, 1'b0);
      chk({tag, "_txd_word"}, {bus.txd_eof, bus.txc_fifo, bus.txd64}, 73'd0);
      chk({tag, "_dropped"}, bus.tx_frame_dropped, 1'b0);
      chk({tag, "_afull"}, bus.tx_fifo_afull, 1'b0);
      chk({tag, "_avail"}, bus.frame_avail, 1'b0);
      chk({tag, "_empty"}, bus.fifo_empty, 1'b1);
   endtask

   task automatic idle_inputs();
      bus.tx_data       = '0;
      bus.tx_data_valid = 8'h00;
      bus.tx_eof        = 1'b0;
      bus.tx_rd_en      = 1'b0;
   endtask

   task automatic clear_model();
      sb.delete();
      pend.delete();
      m_drop    = 0;
      last_word = '0;
   endtask

   initial begin
      masks = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
      tv[0] = '{8'hFF, 1'b0, 1'b0, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b1};
      tv[1] = '{8'hFF, 1'b0, 1'b0, 64'h5555_6666_7777_8888, 1'b0, 1'b0, 1'b1};
      tv[2] = '{8'h0F, 1'b1, 1'b0, 64'h0000_0000_9999_AAAA, 1'b0, 1'b1, 1'b0};
      tv[3] = '{8'h00, 1'b0, 1'b1, 64'h0,                   1'b1, 1'b1, 1'b0};
      tv[4] = '{8'h00, 1'b0, 1'b1, 64'h0,                   1'b1, 1'b1, 1'b0};
      tv[5] = '{8'h00, 1'b0, 1'b1, 64'h0,                   1'b1, 1'b0, 1'b1};
      tv[6] = '{8'h00, 1'b0, 1'b1, 64'h0,                   1'b0, 1'b0, 1'b1};
      tv[7] = '{8'h00, 1'b0, 1'b0, 64'h0,                   1'b0, 1'b0, 1'b1};

      idle_inputs();
      reset = 1'b0;
      repeat (3) @(negedge txclk);
      check_reset_values("por");
      reset = 1'b1;
      @(negedge txclk);

      // three-word frame then three reads, flags from the table
      for (int i = 0; i < 8; i++) begin
         drive_cycle(tv[i].mask, tv[i].eof, tv[i].rd, tv[i].data);
         chk($sformatf("tv%0d_valid", i), bus.txd_valid, tv[i].exp_valid);
         chk($sformatf("tv%0d_avail", i), bus.frame_avail, tv[i].exp_avail);
         chk($sformatf("tv%0d_empty", i), bus.fifo_empty, tv[i].exp_empty);
      end
      chk("tv_last_word", {bus.txd_eof, bus.txc_fifo, bus.txd64}, {1'b1, 8'h0F, 64'h0000_0000_9999_AAAA});

      // 40-word frame: one drop on word 33, then a 2-word frame reads back
      drop_seen = 0;
      write_frame(40, 1'b0);
      chk("oversize_drop_count", drop_seen, 1);
      chk("oversize_empty", bus.fifo_empty, 1'b1);
      write_frame(2, 1'b0);
      read_cycles(3);

      // 30 committed words, second frame dropped at its 3rd word despite a same-cycle read
      write_frame(30, 1'b0);
      drop_seen = 0;
      drive_cycle(8'hFF, 1'b0, 1'b0, rnd64());
      drive_cycle(8'hFF, 1'b0, 1'b0, rnd64());
      drive_cycle(8'hFF, 1'b0, 1'b1, rnd64());
      drive_cycle(8'hFF, 1'b0, 1'b0, rnd64());
      drive_cycle(8'h03, 1'b1, 1'b0, rnd64());
      chk("full_drop_count", drop_seen, 1);
      read_cycles(31);
      chk("full_drain_empty", bus.fifo_empty, 1'b1);

      // 100 single-word frames streamed with continuous reads, wraps pointers
      for (int i = 0; i < 100; i++) drive_cycle(8'h01, 1'b1, 1'b1, rnd64());
      read_cycles(2);

      // reads of an uncommitted frame return nothing and outputs hold
      for (int i = 0; i < 3; i++) drive_cycle(8'hFF, 1'b0, 1'b1, rnd64());
      drive_cycle(8'h07, 1'b1, 1'b1, rnd64());
      read_cycles(6);

      // reset mid-read with a partial frame in flight
      write_frame(10, 1'b0);
      read_cycles(4);
      for (int i = 0; i < 3; i++) drive_cycle(8'hFF, 1'b0, 1'b0, rnd64());
      drive_cycle(8'h00, 1'b0, 1'b1, rnd64());
      #2 reset = 1'b0;
      #1 check_reset_values("async");
      idle_inputs();
      clear_model();
      @(negedge txclk);
      reset = 1'b1;
      @(negedge txclk);
      drive_cycle(8'h1F, 1'b1, 1'b0, rnd64());
      read_cycles(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
